// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port integer register file.
//   RF_WIDTH / RF_DEPTH : default data width and architectural register count
//   rf_addr_t / rf_data_t : register index and register value types
package rf_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used by decode for RAW hazard detection.
// Ports:
//   clk, rst           : clock, async active-high reset (clears every busy bit)
//   wr_en, wr_addr     : write ports; a non-zero write clears its register's busy bit
//   sb_set_en/addr     : issue of a new producer; marks the register busy
//   sb_flush           : clears every busy bit
//   rd_addr            : read-port addresses
//   busy_raw           : registered busy bit of each read-port address (no bypass)
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    input  logic                   sb_flush,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD-1:0]      busy_raw
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Priority, lowest to highest: write clear, new-producer set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
                busy_d[wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0))
            busy_d[sb_set_addr] = 1'b1;
        if (sb_flush)
            busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        busy_raw = '0;
        for (int j = 0; j < NUM_RD; j++)
            busy_raw[j] = busy_q[rd_addr[j*AW +: AW]];
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port integer register file with optional same-cycle
// write-to-read bypass and a busy scoreboard. x0 reads zero and is never busy.
// Ports:
//   clk, rst                 : clock, async active-high reset (regs and busy to 0)
//   wr_en/wr_addr/wr_data    : NUM_WR write ports, port k in slice k
//   rd_addr/rd_data          : NUM_RD combinational read ports, port j in slice j
//   rd_busy                  : per read port, register has an outstanding producer
//   sb_set_en/sb_set_addr    : mark a destination busy at issue
//   sb_flush                 : clear all busy bits
module register_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR*$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]           wr_data,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NUM_RD*WIDTH-1:0]           rd_data,
    output logic [NUM_RD-1:0]                 rd_busy,
    input  logic                              sb_set_en,
    input  logic [$clog2(DEPTH)-1:0]          sb_set_addr,
    input  logic                              sb_flush
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [NUM_RD-1:0] busy_raw;

    // Ports are applied in ascending order so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
                regs_d[wr_addr[k*AW +: AW]] = wr_data[k*WIDTH +: WIDTH];
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .rd_addr     (rd_addr),
        .busy_raw    (busy_raw)
    );

    // Read muxes. rst gates the outputs so that a write forwarded through the
    // bypass cannot leak out while reset is held.
    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rv;
        logic             rb;
        logic             hit;
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra  = rd_addr[j*AW +: AW];
            rv  = regs_q[ra];
            rb  = busy_raw[j];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
                        rv  = wr_data[k*WIDTH +: WIDTH];
                        hit = 1'b1;
                    end
                end
                // A completing write retires the producer, unless a new one
                // issues to the same register this cycle.
                if (hit)
                    rb = sb_set_en && (sb_set_addr == ra);
            end
            if (rst || (ra == '0)) begin
                rv = '0;
                rb = 1'b0;
            end
            rd_data[j*WIDTH +: WIDTH] = rv;
            rd_busy[j]                = rb;
        end
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core. It replaces the single-write/dual-read file so the core can be widened for superscalar or extra-operand use.
- Configurable read and write port counts.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, so decode can detect RAW hazards on outstanding results.
- Register x0 is hardwired to zero and is never busy.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of architectural registers (power of two, >= 2); AW = $clog2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, port k at bits [k*AW +: AW]
wr_data  in  NUM_WR*WIDTH  write data, port k at bits [k*WIDTH +: WIDTH]
rd_addr  in  NUM_RD*AW  read addresses, port j at bits [j*AW +: AW]
rd_data  out  NUM_RD*WIDTH  read data, port j at bits [j*WIDTH +: WIDTH]
rd_busy  out  NUM_RD  1 = register addressed by read port j has a pending producer
sb_set_en  in  1  mark a destination register busy (instruction issued)
sb_set_addr  in  AW  register to mark busy
sb_flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset (rst high, asynchronous): all registers become 0 and all busy bits become 0.
  - While rst is high: rd_data = 0 for every port, rd_busy = 0.
  - A write or sb_set_en presented during reset is ignored.
  - A reset asserted between edges takes effect immediately; it is not deferred to the next edge.
- Writes:
  - On posedge clk, each port k with wr_en[k]=1 and wr_addr != 0 stores wr_data into regs[wr_addr].
  - A write to address 0 is discarded.
  - If two ports write the same address in one cycle, the highest-index port wins.
- Reads (combinational, zero latency):
  - Address 0 always returns 0.
  - With BYPASS=1, if any enabled write port targets the same non-zero address in the current cycle, rd_data returns that port's wr_data. If several ports match, the highest-index port's data is returned.
  - With BYPASS=0, reads return the stored value; the new value is visible from the cycle after the write edge.
- Scoreboard (one busy bit per register, bit 0 tied to 0):
  - Set: on posedge, if sb_set_en=1 and sb_set_addr != 0, busy[sb_set_addr] <= 1.
  - Clear: on posedge, any enabled write port with a non-zero address clears busy[wr_addr].
  - Set and clear of the same address in the same cycle: set wins (a new producer has issued), and the write data is still stored.
  - sb_flush=1 clears all busy bits. Flush takes priority over a set in the same cycle, but writes in that cycle are still performed.
- rd_busy[j] (combinational):
  - Equals busy[rd_addr[j]] after bypass adjustment.
  - With BYPASS=1, a same-cycle enabled write to that address forces rd_busy[j]=0, unless sb_set_en targets the same address in that cycle, in which case rd_busy[j]=1.
  - With BYPASS=0, rd_busy[j] reflects the registered busy bit only.
  - Address 0 always gives rd_busy = 0.
- There is no back-pressure. All inputs are sampled every cycle, and illegal addresses cannot occur because DEPTH is a power of two.

Decomposition:
- Package rf_pkg holds:
  - Default constants RF_WIDTH=32 and RF_DEPTH=32.
  - Typedef rf_addr_t (logic [$clog2(RF_DEPTH)-1:0]).
  - Typedef rf_data_t.
- One sub-module, rf_scoreboard, contains:
  - The DEPTH-bit busy vector.
  - Set/clear/flush priority logic.
  - Per-port busy lookup, with bypass-adjusted outputs driven by the parent.
- The storage array, write arbitration and read bypass muxes stay in register_file_mp.

Test Plan:
- Reset then read: pulse rst mid-cycle after writing x5=0xDEADBEEF → rd_data for x5 reads 0 immediately and rd_busy=0 for all ports.
- Basic write/read: write x7=0x12345678 on port 0; next cycle read x7 on both read ports → both return 0x12345678. Then write x0=0xFFFFFFFF → a read of x0 returns 0.
- Bypass: BYPASS=1, write x3=0xA5A5A5A5 while reading x3 in the same cycle → rd_data=0xA5A5A5A5 that cycle. With BYPASS=0 the same stimulus returns the old value (0), then 0xA5A5A5A5 next cycle.
- Write conflict: NUM_WR=2, port0 writes x9=0x1111, port1 writes x9=0x2222 in the same cycle → x9 reads 0x2222 afterwards, and the bypassed read returns 0x2222 in that cycle.
- Scoreboard lifecycle:
  - sb_set x4 → rd_busy for x4 = 1 next cycle.
  - Write x4 → busy cleared after that edge.
  - Simultaneous sb_set x4 and write x4 → x4 stays busy and holds the new data.
- Flush: mark x1, x2, x31 busy; assert sb_flush together with sb_set x6 → all busy bits are 0 afterwards, including x6. sb_set of x0 never makes x0 busy.
